pipe_hazard_ctrl: RTL

- Parametrised hazard-detection and forwarding controller for the in-order ARM pipeline; successor to the fixed two-stage hazard and forwarding units.
- Keeps its own shadow of in-flight instructions (dest, wb_en, mem_r_en, srcs) for EXE plus FWD_STAGES downstream stages.
- Produces the ID freeze, bubble insertion on freeze/flush, and per-operand forwarding selects for the EXE stage.
- Sits beside the ID/EXE pipeline registers, driven by ID decode outputs and the EXE branch-taken flush.

---
 rtl/pipe_hazard_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard detection and forwarding control for the in-order pipeline.
// Keeps a shadow of in-flight instructions: slot 0 is EXE, slots 1..FWD_STAGES are the
// stages after it. The ID freeze and the EXE operand selects are derived from this shadow.
// Optional build macro HAZ_STALL_CNT_EN adds a saturating 32-bit count of frozen cycles.
module pipe_hazard_ctrl #(
   parameter  int REG_AW     = 4,
   parameter  int FWD_STAGES = 2,
   parameter  int LOAD_LAT   = 1,
   localparam int N          = FWD_STAGES + 1,
   localparam int SW         = $clog2(FWD_STAGES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              forward_en,
   input  logic              flush,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_src1,
   input  logic [REG_AW-1:0] id_src2,
   input  logic              id_two_src,
   input  logic              id_wb_en,
   input  logic              id_mem_r_en,
   input  logic [REG_AW-1:0] id_dest,
   output logic              freeze,
   output logic [SW-1:0]     sel_src1,
   output logic [SW-1:0]     sel_src2,
   output logic [N-1:0]      slot_valid
`ifdef HAZ_STALL_CNT_EN
   ,
   output logic [31:0]       stall_count
`endif
);

   typedef struct packed {
      logic              valid;
      logic              wb_en;
      logic              mem_r_en;
      logic              two_src;
      logic [REG_AW-1:0] dest;
      logic [REG_AW-1:0] src1;
      logic [REG_AW-1:0] src2;
   } slot_t;

   slot_t       slots [N];
   slot_t       id_slot;
   logic [N-1:0] id_hit;
   logic        stall;
   logic        load_id;

   // Pack the ID decode fields into the shape of a slot.
   always_comb begin
      id_slot          = '0;
      id_slot.valid    = 1'b1;
      id_slot.wb_en    = id_wb_en;
      id_slot.mem_r_en = id_mem_r_en;
      id_slot.two_src  = id_two_src;
      id_slot.dest     = id_dest;
      id_slot.src1     = id_src1;
      id_slot.src2     = id_src2;
   end

   // Per-slot hit: does the ID instruction read the register this slot will write.
   always_comb begin
      id_hit = '0;
      for (int k = 0; k < N; k++) begin
         id_hit[k] = id_valid && slots[k].valid && slots[k].wb_en &&
                     ((id_src1 == slots[k].dest) ||
                      (id_two_src && (id_src2 == slots[k].dest)));
      end
   end

   // Freeze: any pending producer without forwarding (WB slot excluded since the
   // register file writes before it is read), or only a load still in its latency
   // window with forwarding. A flushed ID instruction never stalls.
   always_comb begin
      stall = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (forward_en) begin
            if ((k < LOAD_LAT) && slots[k].mem_r_en && id_hit[k]) stall = 1'b1;
         end else begin
            if ((k < N - 1) && id_hit[k]) stall = 1'b1;
         end
      end
      freeze = stall && !flush;
   end

   assign load_id = id_valid && !freeze && !flush;

   // Shift the shadow one slot per cycle; slot 0 takes the ID instruction or a bubble.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < N; k++) slots[k] <= '0;
      end else begin
         slots[0] <= load_id ? id_slot : '0;
         for (int k = 1; k < N; k++) slots[k] <= slots[k-1];
      end
   end

   // Forwarding selects for EXE; scanning oldest to youngest lets the youngest producer win.
   always_comb begin
      sel_src1 = '0;
      sel_src2 = '0;
      if (forward_en && slots[0].valid) begin
         for (int k = N - 1; k >= 1; k--) begin
            if (slots[k].valid && slots[k].wb_en) begin
               if (slots[k].dest == slots[0].src1) sel_src1 = SW'(k);
               if (slots[0].two_src && (slots[k].dest == slots[0].src2)) sel_src2 = SW'(k);
            end
         end
      end
   end

   // Expose the per-slot valid bits, bit 0 = EXE.
   always_comb begin
      slot_valid = '0;
      for (int k = 0; k < N; k++) slot_valid[k] = slots[k].valid;
   end

`ifdef HAZ_STALL_CNT_EN
   // Count frozen cycles, holding at all-ones instead of wrapping.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              stall_count <= '0;
      else if (freeze && (stall_count != '1)) stall_count <= stall_count + 32'd1;
   end
`endif

endmodule
